// File: rtl/seg7_scan_drv.sv
// Multiplexed N-digit seven-segment driver: prescaled digit scan, dead time, PWM dimming,
// leading-zero blanking and frame-synchronous shadow update. an/cat/frame_done are registered (1 cycle).
module seg7_scan_drv #(
    parameter int DIGITS   = 4,
    parameter int CLK_DIV  = 50000,
    parameter int DEAD     = 16,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lzb,
    input  logic [BRIGHT_W-1:0]   bright,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            cat,
    output logic                  frame_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BRIGHT_W-1:0] pwm_q;
    logic [4*DIGITS-1:0] sh_val_q, disp_val_q;
    logic [DIGITS-1:0]   sh_dp_q, sh_blank_q, disp_dp_q, disp_blank_q;
    logic                pend_q;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          cat_q, cat_d;
    logic                fd_q;

    logic       slot_end, frame_end, pwm_on, lit, zero_run;
    logic [3:0] nib;
    logic       sel_dp, sel_blank, sel_lz;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        pwm_on = (bright == '1) || (pwm_q < bright);

        // Walk from the most significant digit down so zero_run covers digits i..DIGITS-1.
        zero_run  = lzb;
        nib       = 4'h0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        sel_lz    = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_val_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                nib       = disp_val_q[4*i +: 4];
                sel_dp    = disp_dp_q[i];
                sel_blank = disp_blank_q[i];
                sel_lz    = zero_run && (i != 0);
            end
        end

        lit = (cnt_q >= CNT_DEAD) && pwm_on && !sel_blank && !sel_lz;
        for (int i = 0; i < DIGITS; i++) begin
            an_d[i] = !(lit && (idx_q == IDX_W'(i)));
        end
        cat_d = lit ? {~sel_dp, seg7(nib)} : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            sh_val_q     <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            pend_q       <= 1'b0;
            an_q         <= '1;
            cat_q        <= 8'hFF;
            fd_q         <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            pwm_q <= pwm_q + 1'b1;
            if (load) begin
                sh_val_q   <= value;
                sh_dp_q    <= dp;
                sh_blank_q <= blank;
            end
            // Transfer takes the pre-load shadow; a load in the boundary cycle waits one frame.
            if (frame_end && pend_q) begin
                disp_val_q   <= sh_val_q;
                disp_dp_q    <= sh_dp_q;
                disp_blank_q <= sh_blank_q;
            end
            pend_q <= load || (pend_q && !frame_end);
            an_q   <= an_d;
            cat_q  <= cat_d;
            fd_q   <= frame_end;
        end
    end

    assign an         = an_q;
    assign cat        = cat_q;
    assign frame_done = fd_q;

endmodule

// File: doc/seg7_scan_drv.md
Name: seg7_scan_drv

Overview:
Parametrised N-digit multiplexed seven-segment driver. It replaces the fixed 4-digit driver and its separate refresh-clock divider: one system clock, an internal prescaler, and a scan FSM. Adds per-digit decimal points, blanking, leading-zero suppression, PWM brightness, anti-ghosting dead time and tear-free frame-synchronous value update. Outputs drive the board anode/cathode pins directly (active-low).

Parameters:
DIGITS, 4, number of digits scanned (1..8)
CLK_DIV, 50000, clk cycles per digit slot (≥ DEAD+2)
DEAD, 16, cycles at start of each slot with all anodes off (≥1, < CLK_DIV)
BRIGHT_W, 4, width of brightness control / PWM counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
value  in  4*DIGITS  hex nibbles; value[3:0] = digit 0 (rightmost)
dp  in  DIGITS  decimal point enable per digit, 1 = lit
blank  in  DIGITS  per-digit force-blank, 1 = dark
lzb  in  1  leading-zero blanking enable
bright  in  BRIGHT_W  brightness; 0 = off, all-ones = full on
load  in  1  capture value/dp/blank into shadow registers
an  out  DIGITS  anodes, active-low, an[i] drives digit i
cat  out  8  cathodes, active-low; cat[7] = dp, cat[6:0] = g..a
frame_done  out  1  one-cycle pulse at end of last digit slot

Behaviour:
- Reset (rst_n=0 at rising edge): an=all ones, cat=8'hFF, frame_done=0; slot counter, digit index, PWM counter, shadow and display registers, pending flag all 0.
- Slot counter cnt: 0..CLK_DIV-1, wraps. At cnt==CLK_DIV-1, idx advances by 1, wrapping DIGITS-1 -> 0.
- Frame boundary = cnt==CLK_DIV-1 && idx==DIGITS-1. frame_done=1 for exactly the following cycle (registered).
- load=1: shadow <= {value,dp,blank}, pending <= 1. At frame boundary with pending=1: display <= shadow, pending <= 0. load in the boundary cycle itself: shadow is updated, pending stays 1, transfer happens at the next boundary. The displayed content never changes mid-frame.
- PWM counter pwm (BRIGHT_W bits): free-running, increments every cycle. pwm_on = (bright == all ones) || (pwm < bright).
- Digit idx is lit when cnt ≥ DEAD && pwm_on && !blank_d[idx] && !lz[idx]. lz[i] = lzb && i≠0 && display nibbles i..DIGITS-1 all zero. Digit 0 is never zero-suppressed.
- Lit: an = ~(1<<idx), cat = {~dp_d[idx], seg(nib)}. Not lit: an = all ones, cat = 8'hFF. blank and lz override dp.
- seg() active-low, dp off (cat value): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- an and cat are registered: they reflect the cnt/idx/pwm/display state of the previous cycle (1-cycle latency). Only one an bit is ever low.
- Changes to bright and lzb take effect immediately (not frame-synchronised). Mid-operation reset returns to digit 0, cnt 0 and clears the display.

Test Plan:
(DIGITS=4, CLK_DIV=8, DEAD=2, BRIGHT_W=2 unless noted)
- Reset then release; load value=16'h1234, dp=0, blank=0, bright=3 -> after first frame boundary, digit slots show an=E/D/B/7 with cat=99,B0,A4,F9 (digit 0 = 4 first). an=F, cat=FF in the first 2 cycles of each slot. frame_done pulses once every 32 cycles.
- load 16'h00A0, lzb=1 -> digits 3,2 dark (an=F whole slot); digit 1 cat=88; digit 0 cat=C0. With lzb=0 -> digits 3,2 show C0.
- load at a mid-frame cycle -> outputs unchanged until after the frame boundary; a second load in the exact boundary cycle -> shown one frame later.
- bright=0 -> an=F always. bright=1 -> within each lit window an low only when pwm==0. bright=3 -> an low for the entire post-DEAD window.
- dp=4'b0010, blank=4'b0001, value=16'h8888 -> digit 1 cat=00; digit 0 dark; digits 2,3 cat=80.
- Assert rst_n=0 mid-slot of digit 2 -> the next cycle has an=F, cat=FF, frame_done=0; after release, scanning restarts at digit 0 with a blank display until the next load plus frame boundary.
